topk_tracker: RTL
=================

// Module: topk_tracker
// PURPOSE
//  Streaming top-K selector, the successor to the single-minimum key/value comparator. It keeps the K best
//  {key,val} pairs of a frame in a sorted array: smallest keys when MODE=0, largest when MODE=1.
//  Each frame arrives as a valid/ready stream ending on i_last. The block then drains its results in rank
//  order on an output valid/ready stream and re-arms for the next frame. It sits between the per-item
//  scoring stage and the result collector.
// PARAMETERS
//  KEY_W  32  key width, unsigned compare
//  VAL_W  16  payload width, carried with its key
//  K      4   number of retained entries (2..16)
//  MODE   0   0 = keep smallest keys, 1 = keep largest keys
// PORTS
//  clk        in   1              single clock, all logic rising-edge
//  rst        in   1              synchronous, active-high reset
//  i_clear    in   1              synchronous frame abort; empties the array and returns to ACCUM
//  i_valid    in   1              input beat valid
//  i_ready    out  1              input beat accepted when i_valid & i_ready
//  i_key      in   KEY_W          input key
//  i_val      in   VAL_W          input payload
//  i_last     in   1              marks the final beat of a frame
//  o_valid    out  1              result beat valid
//  o_ready    in   1              downstream accepts the result beat
//  o_key      out  KEY_W          result key, rank o_rank
//  o_val      out  VAL_W          result payload
//  o_rank     out  clog2(K)       0 = best
//  o_last     out  1              final result beat of the frame
//  o_overflow out  1              more than K beats were seen this frame (some were discarded)
// BEHAVIOUR
//  Reset (rst=1 at the edge): state=ACCUM; every entry invalid; count=0; rd_idx=0.
//   Outputs: o_valid=0, o_key=0, o_val=0, o_rank=0, o_last=0, o_overflow=0.
//  FSM states: ACCUM and DRAIN.
//   In ACCUM, i_ready=1.
//   In DRAIN, i_ready=0 and o_valid=1.
//  Insertion (ACCUM, on accept): the new pair goes into the slot given by its rank among the valid entries.
//   - "Better" is the strict compare: i_key < entry.key when MODE=0, > when MODE=1.
//   - Ties: the earlier arrival keeps the better rank; the new beat goes after every equal key.
//   - Entries at or after the insertion point shift down one slot. Entry K-1 falls off.
//   - A beat that is not better than a full array's entry K-1 is discarded.
//   - count saturates at K. o_overflow is set on any accept while count==K and is cleared on re-arm.
//   - Latency: the array reflects the beat on the cycle after it is accepted.
//   - The per-cycle compare is parallel. The insertion position comes from a K-wide better-than vector
//     (thermometer code), not a sequential scan.
//  ACCUM -> DRAIN: on the edge where a beat with i_last=1 is accepted. That beat is inserted in the same
//   edge. o_valid=1 on the next cycle and presents rank 0 (the array is already updated).
//  DRAIN:
//   - o_key, o_val and o_rank show entry[rd_idx], with o_rank=rd_idx.
//   - o_last=1 when rd_idx==count-1. count is at least 1, because i_last rides on a beat.
//   - On o_valid & o_ready: rd_idx increments.
//   - On o_valid & o_ready & o_last: return to ACCUM; all entries invalid, count=0, rd_idx=0, o_overflow=0.
//   - Outputs hold stable while o_ready=0. Backpressure may last indefinitely.
//  o_overflow stays visible throughout DRAIN.
//  Outside DRAIN, o_key, o_val and o_rank are don't-care but driven deterministically (entry[0]);
//   o_last=0 and o_valid=0.
//  i_clear (either state): at the edge, empty the array and set count=0, rd_idx=0, o_overflow=0,
//   state=ACCUM. Any beat presented in the same cycle is dropped.
//   Priority order: rst > i_clear > normal operation.
//  Reset or clear mid-DRAIN: o_valid falls on the next cycle. No partial results survive.
//  Width rules:
//   - count is clog2(K+1) bits; rd_idx is clog2(K) bits.
//   - Keys are compared unsigned at full KEY_W. Payloads are never compared.
// STRUCTURE
//  Shared package topk_pkg: FSM state encoding (ST_ACCUM, ST_DRAIN) and a CLOG2 helper function.
//  Sub-module topk_cell, instantiated K times, each holding one {valid,key,val} slot. Per cycle it:
//   - produces its better-than bit,
//   - takes the new pair, its upper neighbour's entry, or holds,
//   - from select lines driven by the top-level thermometer logic.
//  The top level holds the FSM, count, rd_idx, the overflow flag and the output mux.
// TESTING
//  1. K=4, MODE=0. Frame keys 9,3,7,1,5 (vals 0..4), last on 5, o_ready=1.
//     -> results (1,v3),(3,v1),(5,v4),(7,v2); o_rank 0..3; o_last on 4th beat; o_overflow=1.
//  2. Frame of 2 beats, keys 8,2. -> 2 results (2 then 8); o_last on 2nd beat; o_overflow=0;
//     o_valid asserted exactly 1 cycle after the i_last accept.
//  3. Ties: keys 4(v=A),4(v=B),4(v=C). -> output order A,B,C.
//     MODE=1 with keys 1,9,5 -> 9,5,1.
//  4. Backpressure: hold o_ready=0 for 10 cycles in DRAIN. -> outputs stable, i_ready=0,
//     extra input beats not accepted; then drain completes normally.
//  5. i_clear asserted mid-frame after 3 beats, then a new frame with key 6 last.
//     -> a single result 6 with o_last=1; earlier keys absent.
//  6. rst pulse during DRAIN at rank 1. -> o_valid=0 on the next cycle; the following frame drains
//     only its own beats.

Source files
------------

// File: rtl/topk_pkg.sv
// Shared types and helpers for the streaming top-K tracker.
package topk_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  function automatic int CLOG2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/topk_cell.sv
// One slot of the sorted top-K array: holds {valid,key,val}, reports whether the
// incoming key beats it, and loads either the new pair or its upper neighbour.
module topk_cell #(
  parameter int KEY_W = 32,
  parameter int VAL_W = 16,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             take_new,
  input  logic             take_up,
  input  logic [KEY_W-1:0] new_key,
  input  logic [VAL_W-1:0] new_val,
  input  logic             up_valid,
  input  logic [KEY_W-1:0] up_key,
  input  logic [VAL_W-1:0] up_val,
  output logic             valid,
  output logic [KEY_W-1:0] key,
  output logic [VAL_W-1:0] val,
  output logic             better
);

  // Strict compare keeps earlier arrivals ahead of equal keys; an empty slot always loses.
  assign better = !valid || ((MODE != 0) ? (new_key > key) : (new_key < key));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= 1'b0;
      key   <= '0;
      val   <= '0;
    end else if (take_new) begin
      valid <= 1'b1;
      key   <= new_key;
      val   <= new_val;
    end else if (take_up) begin
      valid <= up_valid;
      key   <= up_key;
      val   <= up_val;
    end
  end

endmodule

// File: rtl/topk_tracker.sv
// Streaming top-K selector: sorted insertion during ACCUM, rank-ordered drain in DRAIN.
module topk_tracker
  import topk_pkg::*;
#(
  parameter int KEY_W = 32,
  parameter int VAL_W = 16,
  parameter int K     = 4,
  parameter int MODE  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [KEY_W-1:0]    i_key,
  input  logic [VAL_W-1:0]    i_val,
  input  logic                i_last,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [KEY_W-1:0]    o_key,
  output logic [VAL_W-1:0]    o_val,
  output logic [CLOG2(K)-1:0] o_rank,
  output logic                o_last,
  output logic                o_overflow
);

  localparam int CW = CLOG2(K + 1);
  localparam int RW = CLOG2(K);

  state_t        state;
  logic [CW-1:0] count;
  logic [RW-1:0] rd_idx;
  logic          ovf;

  logic [K-1:0]            ent_valid, better, take_new, take_up, up_valid;
  logic [K-1:0][KEY_W-1:0] ent_key, up_key;
  logic [K-1:0][VAL_W-1:0] ent_val, up_val;

  logic accept, rearm;

  assign i_ready    = (state == ST_ACCUM);
  assign o_valid    = (state == ST_DRAIN);
  assign accept     = i_valid && i_ready && !i_clear;
  assign o_last     = o_valid && ((CW'(rd_idx) + CW'(1)) == count);
  assign rearm      = o_valid && o_ready && o_last;
  assign o_key      = ent_key[rd_idx];
  assign o_val      = ent_val[rd_idx];
  assign o_rank     = rd_idx;
  assign o_overflow = ovf;

  // better[] is a thermometer (0..0 1..1); the new pair lands at its first 1,
  // slots below that shift down, and an all-zero vector discards the beat.
  for (genvar i = 0; i < K; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign take_new[i] = accept && better[i];
      assign take_up[i]  = 1'b0;
      assign up_valid[i] = 1'b0;
      assign up_key[i]   = '0;
      assign up_val[i]   = '0;
    end else begin : g_body
      assign take_new[i] = accept && better[i] && !better[i-1];
      assign take_up[i]  = accept && better[i] && better[i-1];
      assign up_valid[i] = ent_valid[i-1];
      assign up_key[i]   = ent_key[i-1];
      assign up_val[i]   = ent_val[i-1];
    end

    topk_cell #(.KEY_W(KEY_W), .VAL_W(VAL_W), .MODE(MODE)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .clr      (i_clear || rearm),
      .take_new (take_new[i]),
      .take_up  (take_up[i]),
      .new_key  (i_key),
      .new_val  (i_val),
      .up_valid (up_valid[i]),
      .up_key   (up_key[i]),
      .up_val   (up_val[i]),
      .valid    (ent_valid[i]),
      .key      (ent_key[i]),
      .val      (ent_val[i]),
      .better   (better[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      state  <= ST_ACCUM;
      count  <= '0;
      rd_idx <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            if (count == CW'(K)) ovf <= 1'b1;
            else                 count <= count + CW'(1);
            if (i_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (o_ready) begin
            if (o_last) begin
              state  <= ST_ACCUM;
              count  <= '0;
              rd_idx <= '0;
              ovf    <= 1'b0;
            end else begin
              rd_idx <= rd_idx + RW'(1);
            end
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule
